// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Program-counter and instruction-fetch sequencer for MINI_MIPS. It computes the value the
//   external PC register loads every clock. It issues one instruction-memory request per PC
//   and hands the fetched word to decode. It also applies branch/jump redirects, the
//   exception vector, fetch timeouts and halt.
//
// Parameters
//   EXC_VECTOR  PC loaded on exception, misaligned redirect target or fetch timeout
//   TIMEOUT     max cycles imem_req may stay unacknowledged (>= 2)
//
// Ports
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   pc               current PC (PC register output)
//   next_pc          value the PC register loads on the next clk (holds pc by default)
//   imem_req/addr    fetch request and address, held until imem_ack
//   imem_ack/rdata   fetch completion and fetched word
//   instr_valid/instr/instr_pc/instr_ready   decode handshake
//   redirect_valid/redirect_target           taken branch/jump pulse and target
//   exception        1-cycle pulse, vector to EXC_VECTOR
//   halt             stop fetching until reset
//   fetch_err        1-cycle pulse on timeout or misaligned redirect target
//   halted           high once halted

module pc_fetch_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exception,
  input  logic        halt,
  output logic        fetch_err,
  output logic        halted
);

  localparam int unsigned   CntW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDeliver,
    StHalted
  } state_e;

  state_e          state;
  logic            pending;
  logic [31:0]     pend_tgt;
  logic [CntW-1:0] wait_cnt;

  // Event decode for this cycle. Exception outranks redirect, and a misaligned redirect
  // target is turned into an exception.
  logic        evt;
  logic        evt_misaligned;
  logic [31:0] evt_tgt;
  logic        redir_now;
  logic [31:0] redir_tgt;
  logic        timeout;

  always_comb begin
    evt            = exception | redirect_valid;
    evt_misaligned = redirect_valid & ~exception & (redirect_target[1:0] != 2'b00);
    evt_tgt        = (exception | evt_misaligned) ? EXC_VECTOR : redirect_target;
    // An event arriving in the same cycle as the ack is applied immediately. It also
    // overrides any older pending target.
    redir_now      = pending | evt;
    redir_tgt      = evt ? evt_tgt : pend_tgt;
    timeout        = (wait_cnt == CntLast) & ~imem_ack;
  end

  // Combinational PC steering and request.
  always_comb begin
    next_pc   = pc;
    imem_req  = (state == StFetch);
    imem_addr = pc;
    halted    = (state == StHalted);
    unique case (state)
      StIdle, StDeliver: begin
        if (!halt && evt) next_pc = evt_tgt;
      end
      StFetch: begin
        if (!halt) begin
          if (imem_ack) begin
            next_pc = redir_now ? redir_tgt : pc + 32'd4;
          end else if (timeout) begin
            next_pc = evt ? evt_tgt : EXC_VECTOR;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_err   <= 1'b0;
      pending     <= 1'b0;
      pend_tgt    <= '0;
      wait_cnt    <= '0;
    end else begin
      fetch_err <= 1'b0;
      if (halt) begin
        // An outstanding request is abandoned and any late ack is ignored.
        state       <= StHalted;
        instr_valid <= 1'b0;
        pending     <= 1'b0;
        wait_cnt    <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            state       <= StFetch;
            wait_cnt    <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= evt_misaligned;
          end
          StFetch: begin
            if (imem_ack) begin
              wait_cnt  <= '0;
              pending   <= 1'b0;
              fetch_err <= evt_misaligned;
              if (!redir_now) begin
                instr       <= imem_rdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                state       <= StDeliver;
              end
              // With a redirect the data is dropped. The new request goes out next cycle
              // once the PC has loaded the target.
            end else if (timeout) begin
              // Drop the request for one cycle through idle, then fetch at the vector.
              fetch_err <= 1'b1;
              pending   <= 1'b0;
              wait_cnt  <= '0;
              state     <= StIdle;
            end else begin
              wait_cnt <= wait_cnt + CntW'(1);
              if (evt) begin
                pending   <= 1'b1;
                pend_tgt  <= evt_tgt;
                fetch_err <= evt_misaligned;
              end
            end
          end
          StDeliver: begin
            if (evt) begin
              // Squash the instruction even if decode is ready this cycle.
              instr_valid <= 1'b0;
              fetch_err   <= evt_misaligned;
              wait_cnt    <= '0;
              state       <= StFetch;
            end else if (instr_ready) begin
              instr_valid <= 1'b0;
              wait_cnt    <= '0;
              state       <= StFetch;
            end
          end
          StHalted: ;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

  localparam logic [31:0] EXC = 32'h0000_0080;
  localparam int          TO  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        exception = 1'b0;
  logic        halt = 1'b0;
  logic        fetch_err;
  logic        halted;

  pc_fetch_sequencer #(
    .EXC_VECTOR(EXC),
    .TIMEOUT   (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .next_pc        (next_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .exception      (exception),
    .halt           (halt),
    .fetch_err      (fetch_err),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // External PC register.
  always @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else       pc <= next_pc;
  end

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_instr_q[$];
  int          exp_err_q[$];
  logic [31:0] cur;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;

  // Instruction memory contents as a function of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F96;
  endfunction

  // Architectural target of an event.
  function automatic logic [31:0] model_tgt(input logic exc, input logic [31:0] t);
    if (exc) return EXC;
    if (t[1:0] != 2'b00) return EXC;
    return t;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected no event", name, act);
  endtask

  // Monitor: pops expectations whenever the DUT presents a request, a delivery or an error.
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_req && (!prev_req || prev_ack)) begin
        if (exp_addr_q.size() == 0) unexpected("req_addr", imem_addr);
        else check32("req_addr", imem_addr, exp_addr_q.pop_front());
      end
      if (instr_valid && instr_ready && !redirect_valid && !exception && !halt) begin
        if (exp_instr_q.size() == 0) begin
          unexpected("deliver", instr_pc);
        end else begin
          logic [63:0] e;
          e = exp_instr_q.pop_front();
          check32("instr_pc", instr_pc, e[63:32]);
          check32("instr", instr, e[31:0]);
        end
      end
      if (fetch_err) begin
        if (exp_err_q.size() == 0) begin
          unexpected("fetch_err", 32'(fetch_err));
        end else begin
          void'(exp_err_q.pop_front());
          checks++;
        end
      end
    end
    prev_req = imem_req & ~reset;
    prev_ack = imem_ack;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    exception      = 1'b0;
    halt           = 1'b0;
    imem_rdata     = 32'hDEAD_BEEF;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 8) begin
      step();
      n++;
    end
    check32("wait_req", 32'(imem_req), 32'd1);
  endtask

  // Drive one event; returns its architectural target and queues an error if expected.
  task automatic fire(input logic exc, input logic rv, input logic [31:0] t,
                      output logic [31:0] nt);
    exception       = exc;
    redirect_valid  = rv;
    redirect_target = t;
    nt = model_tgt(exc, t);
    if (rv && !exc && t[1:0] != 2'b00) exp_err_q.push_back(1);
  endtask

  task automatic ep_normal(input int d, input int s);
    wait_req();
    repeat (d) step();
    exp_instr_q.push_back({cur, mem(cur)});
    exp_addr_q.push_back(cur + 32'd4);
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = mem(imem_addr);
    step();
    clear_in();
    for (int i = 0; i < s; i++) begin
      check32("stall_req", 32'(imem_req), 32'd0);
      check32("stall_instr", instr, mem(cur));
      check32("stall_pc", pc, cur + 32'd4);
      step();
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    cur = cur + 32'd4;
  endtask

  task automatic ep_fetch_redirect(input logic exc, input logic rv, input logic [31:0] t,
                                   input int d1, input int d2, input logic second);
    logic [31:0] nt;
    wait_req();
    repeat (d1) step();
    fire(exc, rv, t, nt);
    if (d2 < 0) begin
      exp_addr_q.push_back(nt);
      imem_ack   = 1'b1;
      imem_rdata = 32'h0BAD_0BAD;
      step();
      clear_in();
    end else begin
      step();
      clear_in();
      repeat (d2) step();
      if (second) begin
        fire(1'b0, 1'b1, {$urandom_range(0, 32'hFFFF), 2'b00}, nt);
        step();
        clear_in();
      end
      exp_addr_q.push_back(nt);
      imem_ack   = 1'b1;
      imem_rdata = 32'h0BAD_0BAD;
      step();
      clear_in();
      check32("discard_valid", 32'(instr_valid), 32'd0);
    end
    cur = nt;
  endtask

  task automatic ep_deliver_redirect(input logic exc, input logic rv, input logic [31:0] t,
                                     input int s, input logic rdy);
    logic [31:0] nt;
    wait_req();
    imem_ack   = 1'b1;
    imem_rdata = mem(imem_addr);
    step();
    clear_in();
    repeat (s) step();
    fire(exc, rv, t, nt);
    exp_addr_q.push_back(nt);
    instr_ready = rdy;
    step();
    clear_in();
    instr_ready = 1'b0;
    check32("squash_valid", 32'(instr_valid), 32'd0);
    cur = nt;
  endtask

  task automatic ep_timeout();
    int n = 0;
    wait_req();
    exp_err_q.push_back(1);
    exp_addr_q.push_back(EXC);
    while (imem_req && n < TO + 4) begin
      step();
      n++;
    end
    check32("timeout_cycles", 32'(n), 32'(TO));
    check32("timeout_pc", pc, EXC);
    cur = EXC;
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    clear_in();
    #12;
    check32("rst_valid", 32'(instr_valid), 32'd0);
    check32("rst_instr", instr, 32'd0);
    check32("rst_instr_pc", instr_pc, 32'd0);
    check32("rst_err", 32'(fetch_err), 32'd0);
    check32("rst_req", 32'(imem_req), 32'd0);
    check32("rst_halted", 32'(halted), 32'd0);
    check32("rst_next_pc", next_pc, 32'd0);
    cur = 32'd0;
    exp_addr_q.push_back(32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    step();

    repeat (4) ep_normal(0, 0);
    ep_normal(0, 5);
    ep_fetch_redirect(1'b0, 1'b1, 32'h40, 0, 2, 1'b0);
    ep_normal(1, 0);
    ep_fetch_redirect(1'b1, 1'b1, 32'h40, 1, 0, 1'b0);
    ep_fetch_redirect(1'b0, 1'b1, 32'h42, 0, 1, 1'b0);
    ep_fetch_redirect(1'b0, 1'b1, 32'h100, 0, -1, 1'b0);
    ep_deliver_redirect(1'b0, 1'b1, 32'hFFFF_FFFC, 1, 1'b1);
    ep_normal(0, 1);
    ep_normal(2, 0);
    ep_timeout();
    ep_normal(0, 0);

    for (int i = 0; i < 40; i++) begin
      int          kind;
      logic        exc;
      logic        rv;
      logic [31:0] t;
      kind = $urandom_range(0, 9);
      exc  = ($urandom_range(0, 3) == 0);
      rv   = !exc || ($urandom_range(0, 1) == 1);
      t    = $urandom;
      t[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (kind < 5) begin
        ep_normal($urandom_range(0, 3), $urandom_range(0, 3));
      end else if (kind < 7) begin
        ep_fetch_redirect(exc, rv, t, $urandom_range(0, 3), $urandom_range(0, 4) - 1,
                          1'($urandom_range(0, 1)));
      end else if (kind < 9) begin
        ep_deliver_redirect(exc, rv, t, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end else begin
        ep_timeout();
      end
    end

    // Reset in the middle of a request drops imem_req without waiting for a clock.
    wait_req();
    step();
    #2 reset = 1'b1;
    #1;
    check32("async_req_drop", 32'(imem_req), 32'd0);
    check32("async_valid", 32'(instr_valid), 32'd0);
    exp_addr_q.push_back(32'd0);
    cur = 32'd0;
    @(posedge clk);
    #3 reset = 1'b0;
    step();
    ep_normal(0, 0);
    ep_normal(1, 1);

    // Halt during an outstanding request; the late ack and later redirect are ignored.
    wait_req();
    step();
    halt = 1'b1;
    step();
    clear_in();
    imem_ack   = 1'b1;
    imem_rdata = mem(imem_addr);
    step();
    clear_in();
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    instr_ready     = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check32("halt_req", 32'(imem_req), 32'd0);
      check32("halt_flag", 32'(halted), 32'd1);
      check32("halt_valid", 32'(instr_valid), 32'd0);
      step();
      redirect_valid = 1'b0;
    end
    instr_ready = 1'b0;

    check32("left_addr", 32'(exp_addr_q.size()), 32'd0);
    check32("left_instr", 32'(exp_instr_q.size()), 32'd0);
    check32("left_err", 32'(exp_err_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
